// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO of (inst, pc) pairs.
// It has registered-only output visibility, and flush or reset discards every entry on the edge.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_inst,
  input  logic [WIDTH-1:0]         in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_inst,
  output logic [WIDTH-1:0]         out_pc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;

  // in_ready depends on state only, so a full queue never accepts even when popping.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_inst = out_valid ? inst_mem[head] : '0;
  assign out_pc   = out_valid ? pc_mem[head]   : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; validity comes from head/tail/count alone.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      inst_mem[tail] <= in_inst;
      pc_mem[tail]   <= in_pc;
    end
  end

endmodule
